// File: rtl/cpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_if
// Bundles the sequencer's control and instruction-bus signals.
//   master : the sequencer (drives pc/ir/write enables/status)
//   slave  : the datapath / instruction memory / decoder side
// Signals:
//   run, instr_in, jump, branch, memwrite, regwrite, is_zero  -> sequencer
//   pc, ir, reg_we, mem_we, halted, state (, retired)         <- sequencer
// The retired count exists only when CPU_SEQ_PERF_EN is defined.
// ---------------------------------------------------------------------------
interface cpu_sequencer_if;
  logic        run;
  logic [15:0] instr_in;
  logic        jump;
  logic        branch;
  logic        memwrite;
  logic        regwrite;
  logic        is_zero;
  logic [15:0] pc;
  logic [15:0] ir;
  logic        reg_we;
  logic        mem_we;
  logic        halted;
  logic [2:0]  state;
`ifdef CPU_SEQ_PERF_EN
  logic [15:0] retired;
`endif

  modport master (
    input  run, instr_in, jump, branch, memwrite, regwrite, is_zero,
    output pc, ir, reg_we, mem_we, halted, state
`ifdef CPU_SEQ_PERF_EN
    , output retired
`endif
  );

  modport slave (
    output run, instr_in, jump, branch, memwrite, regwrite, is_zero,
    input  pc, ir, reg_we, mem_we, halted, state
`ifdef CPU_SEQ_PERF_EN
    , input retired
`endif
  );
endinterface

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle control sequencer for the 16-bit CPU. Owns pc and ir and steps
// each instruction through FETCH -> DECODE -> EXECUTE -> WRITEBACK (4 clk).
// Register-file and data-memory write enables are gated to WRITEBACK so each
// fires once per instruction. HALT is absorbing; only rst leaves it.
//
// Ports:
//   clk  - system clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - cpu_sequencer_if.master (run, instr_in, decode flags, is_zero in;
//          pc, ir, reg_we, mem_we, halted, state, retired out)
//
// Parameters:
//   PC_RESET  - pc value loaded by rst
//   PC_LIMIT  - a fetch attempted at pc > PC_LIMIT halts instead
//   HALT_WORD - instruction encoding that halts the sequencer
//
// Optional feature macro: CPU_SEQ_PERF_EN adds the 16-bit retired-instruction
// counter (bus.retired). Without it the counter and port do not exist.
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter logic [15:0] PC_RESET  = 16'h0000,
  parameter logic [15:0] PC_LIMIT  = 16'hFFFF,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic            clk,
  input  logic            rst,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALT      = 3'd4
  } state_t;

  state_t      state_reg;
  logic [15:0] pc_reg;
  logic [15:0] ir_reg;
  logic        zero_q_reg;
  logic        halted_reg;

  logic [15:0] pc_next;
  logic [15:0] branch_offset;
  logic        pc_over_limit;

  // Sign-extended 7-bit branch displacement (-64..+63).
  assign branch_offset = {{9{ir_reg[6]}}, ir_reg[6:0]};

  // Widened by one bit so the comparison stays meaningful when PC_LIMIT is
  // the all-ones value (the limit can then never be exceeded).
  assign pc_over_limit = ({1'b0, pc_reg} > {1'b0, PC_LIMIT});

  // Next-pc selection; jump beats branch. All sums wrap at 16 bits.
  always_comb begin
    pc_next = pc_reg + 16'd1;
    if (bus.jump) begin
      pc_next = {pc_reg[15:13], ir_reg[12:0]};
    end else if (bus.branch && zero_q_reg) begin
      pc_next = pc_reg + 16'd1 + branch_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= FETCH;
      pc_reg     <= PC_RESET;
      ir_reg     <= 16'h0000;
      zero_q_reg <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          // run is only consulted here, so dropping it mid-instruction lets
          // the current instruction finish before idling.
          if (bus.run) begin
            if (pc_over_limit) begin
              state_reg  <= HALT;
              halted_reg <= 1'b1;
            end else begin
              ir_reg    <= bus.instr_in;
              state_reg <= DECODE;
            end
          end
        end
        DECODE: begin
          if (ir_reg == HALT_WORD) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end else begin
            state_reg <= EXECUTE;
          end
        end
        EXECUTE: begin
          // The zero flag is captured once so a branch decision cannot be
          // disturbed by the ALU output changing during WRITEBACK.
          zero_q_reg <= bus.is_zero;
          state_reg  <= WRITEBACK;
        end
        WRITEBACK: begin
          pc_reg    <= pc_next;
          state_reg <= FETCH;
        end
        HALT: begin
          state_reg <= HALT;
        end
        default: begin
          state_reg <= FETCH;
        end
      endcase
    end
  end

`ifdef CPU_SEQ_PERF_EN
  logic [15:0] retired_reg;

  // Counts WRITEBACK->FETCH transitions; naturally frozen in HALT because
  // WRITEBACK is never reached there.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_reg <= 16'h0000;
    end else if (state_reg == WRITEBACK) begin
      retired_reg <= retired_reg + 16'd1;
    end
  end

  assign bus.retired = retired_reg;
`endif

  // Write enables are combinational from the decode flags but qualified by
  // the WRITEBACK state and masked by rst so nothing is written in a reset
  // cycle, even one that interrupts WRITEBACK.
  assign bus.reg_we = (state_reg == WRITEBACK) && bus.regwrite && !rst;
  assign bus.mem_we = (state_reg == WRITEBACK) && bus.memwrite && !rst;

  assign bus.pc     = pc_reg;
  assign bus.ir     = ir_reg;
  assign bus.halted = halted_reg;
  assign bus.state  = state_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
// Drives cpu_sequencer with directed programs and a randomized program held
// in a 64K-word memory. Instruction encoding used by the bench's decoder:
//   ir[15]=jump, ir[14]=branch, ir[13]=memwrite, ir[7]=regwrite.
// The stimulus walks a per-instruction program model and queues the expected
// WRITEBACK/HALT events; a monitor pops and compares them as they appear.
// A second instance with PC_LIMIT=3 checks the fetch-limit halt.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic is_zero = 1'b0;
  logic run_lim = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:65535];

  cpu_sequencer_if bus ();
  cpu_sequencer_if bus_lim ();

  assign bus.run      = run;
  assign bus.is_zero  = is_zero;
  assign bus.instr_in = mem[bus.pc];
  assign bus.jump     = bus.ir[15];
  assign bus.branch   = bus.ir[14];
  assign bus.memwrite = bus.ir[13];
  assign bus.regwrite = bus.ir[7];

  assign bus_lim.run      = run_lim;
  assign bus_lim.is_zero  = 1'b0;
  assign bus_lim.instr_in = 16'h0080;
  assign bus_lim.jump     = bus_lim.ir[15];
  assign bus_lim.branch   = bus_lim.ir[14];
  assign bus_lim.memwrite = bus_lim.ir[13];
  assign bus_lim.regwrite = bus_lim.ir[7];

  cpu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cpu_sequencer #(.PC_LIMIT(16'h0003)) dut_lim (
    .clk (clk),
    .rst (rst),
    .bus (bus_lim)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_halt;
    logic [15:0] pc;
    logic [15:0] ir;
    bit          rw;
    bit          mw;
    logic [15:0] npc;
    logic [15:0] ret;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Program model: next pc from the architectural rules.
  function automatic logic [15:0] model_next(input logic [15:0] p, input logic [15:0] w, input bit z);
    int          off;
    logic [31:0] t;
    if (w[15]) return {p[15:13], w[12:0]};
    if (w[14] && z) begin
      off = w[6] ? int'(w[6:0]) - 128 : int'(w[6:0]);
      t = 32'(int'(p) + 1 + off);
      return t[15:0];
    end
    t = 32'(int'(p) + 1);
    return t[15:0];
  endfunction

  // ---------------- monitor ----------------
  exp_t        mon_e;
  bit          npc_pending = 0;
  logic [15:0] npc_exp;
  logic [15:0] ret_exp;
  bit          halt_seen = 0;
  logic [15:0] halt_pc;

  always @(negedge clk) begin
    if (rst) begin
      check("we_in_reset", 32'({bus.reg_we, bus.mem_we}), 32'd0);
      npc_pending = 0;
      halt_seen = 0;
    end else begin
      if (npc_pending) begin
        check("next_pc", 32'(bus.pc), 32'(npc_exp));
        check("state_after_wb", 32'(bus.state), 32'd0);
`ifdef CPU_SEQ_PERF_EN
        check("retired", 32'(bus.retired), 32'(ret_exp));
`endif
        npc_pending = 0;
      end
      if (bus.state == 3'd3) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wb_kind", 32'(mon_e.is_halt), 32'd0);
          check("wb_pc", 32'(bus.pc), 32'(mon_e.pc));
          check("wb_ir", 32'(bus.ir), 32'(mon_e.ir));
          check("wb_reg_we", 32'(bus.reg_we), 32'(mon_e.rw));
          check("wb_mem_we", 32'(bus.mem_we), 32'(mon_e.mw));
          check("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
          $display("[TB] wb pc=%h ir=%h reg_we=%b mem_we=%b next=%h",
                   bus.pc, bus.ir, bus.reg_we, bus.mem_we, mon_e.npc);
          npc_exp = mon_e.npc;
          ret_exp = mon_e.ret;
          npc_pending = 1;
        end
      end else begin
        check("we_outside_wb", 32'({bus.reg_we, bus.mem_we}), 32'd0);
      end
      if (bus.halted && !halt_seen) begin
        halt_seen = 1;
        halt_pc = bus.pc;
        if (exp_q.size() == 0) begin
          check("unexpected_halt", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("halt_kind", 32'(mon_e.is_halt), 32'd1);
          check("halt_pc", 32'(bus.pc), 32'(mon_e.pc));
          check("halt_ir", 32'(bus.ir), 32'(HALT_WORD));
          check("halt_cycle", 32'(cyc), 32'(mon_e.cyc));
          $display("[TB] halt pc=%h ir=%h", bus.pc, bus.ir);
        end
      end else if (halt_seen) begin
        check("halt_hold_pc", 32'(bus.pc), 32'(halt_pc));
        check("halt_hold_state", 32'(bus.state), 32'd4);
        check("halt_hold_flag", 32'(bus.halted), 32'd1);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [15:0] m_pc;
  bit          m_halted;
  logic [15:0] exp_retired;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_pc", 32'(bus.pc), 32'h0000);
    check("rst_ir", 32'(bus.ir), 32'h0000);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_we", 32'({bus.reg_we, bus.mem_we}), 32'd0);
`ifdef CPU_SEQ_PERF_EN
    check("rst_retired", 32'(bus.retired), 32'd0);
`endif
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    run = 1'b0;
    run_lim = 1'b0;
    tick();
    tick();
    check_reset_state();
    rst = 1'b0;
    m_pc = 16'h0000;
    m_halted = 0;
    exp_retired = 16'h0000;
  endtask

  // One instruction from the model pc. zmode: 0/1 force is_zero in EXECUTE,
  // 2 = random. gap = idle FETCH cycles with run low before it.
  task automatic step(input int gap, input int zmode);
    logic [15:0] w;
    bit          z;
    exp_t        e;
    w = mem[m_pc];
    z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    repeat (gap) begin
      run = 1'b0;
      is_zero = 1'($urandom_range(0, 1));
      tick();
    end
    run = 1'b1;
    is_zero = 1'($urandom_range(0, 1));
    e.pc = m_pc;
    e.ir = w;
    if (w == HALT_WORD) begin
      e.is_halt = 1;
      e.rw = 0;
      e.mw = 0;
      e.npc = m_pc;
      e.ret = exp_retired;
      e.cyc = cyc + 2;
      exp_q.push_back(e);
      tick();
      tick();
      m_halted = 1;
      return;
    end
    e.is_halt = 0;
    e.rw = w[7];
    e.mw = w[13];
    e.npc = model_next(m_pc, w, z);
    exp_retired = exp_retired + 16'd1;
    e.ret = exp_retired;
    e.cyc = cyc + 3;
    exp_q.push_back(e);
    tick();
    check("ir_latch", 32'(bus.ir), 32'(w));
    run = 1'($urandom_range(0, 1));
    is_zero = 1'($urandom_range(0, 1));
    tick();
    run = 1'($urandom_range(0, 1));
    is_zero = z;
    tick();
    run = 1'($urandom_range(0, 1));
    is_zero = 1'($urandom_range(0, 1));
    tick();
    run = 1'b0;
    m_pc = e.npc;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    for (int a = 0; a < 65536; a++) begin
      r = 16'($urandom);
      if (r == HALT_WORD) r = 16'h0000;
      mem[a] = r;
    end

    // Idle after reset, then four ALU instructions.
    reset_dut();
    repeat (10) tick();
    check("idle_state", 32'(bus.state), 32'd0);
    check("idle_pc", 32'(bus.pc), 32'd0);
    check("idle_ir", 32'(bus.ir), 32'd0);
    for (int a = 0; a < 4; a++) mem[a] = 16'h0080 | (16'($urandom) & 16'h1F7F);
    for (int i = 0; i < 4; i++) step(0, 2);
    check("alu_pc_end", 32'(bus.pc), 32'h0004);

    // Branch by -2 taken and not taken at pc 5.
    mem[0] = 16'h8005;
    mem[5] = 16'h407E;
    reset_dut();
    step(0, 2);
    step(0, 1);
    check("branch_taken_pc", 32'(bus.pc), 32'h0004);
    reset_dut();
    step(0, 2);
    step(0, 0);
    check("branch_not_taken_pc", 32'(bus.pc), 32'h0006);

    // Jump priority at 0x2005, then climb the 8K regions to wrap 0xFFFF->0.
    mem[0] = 16'h9FFF;
    mem[16'h2000] = 16'h8005;
    mem[16'h2005] = 16'hC100;
    mem[16'h2100] = 16'h9FFF;
    for (int k = 0; k < 8; k++) begin
      mem[k * 8192 + 8191] = 16'h0000;
      if (k >= 2) mem[k * 8192] = 16'h9FFF;
    end
    reset_dut();
    for (int i = 0; i < 4; i++) step(0, 1);
    check("jump_priority_pc", 32'(bus.pc), 32'h2100);
    for (int i = 0; i < 14; i++) step($urandom_range(0, 1), 2);
    check("wrap_pc", 32'(bus.pc), 32'h0000);

    // HALT_WORD at pc 2.
    mem[0] = 16'h0080;
    mem[1] = 16'h2081;
    mem[2] = HALT_WORD;
    reset_dut();
    for (int i = 0; i < 3; i++) step(0, 2);
    repeat (5) begin
      run = 1'b1;
      tick();
    end
    check("halt_final_pc", 32'(bus.pc), 32'h0002);
    check("halt_final_flag", 32'(bus.halted), 32'd1);

    // Three instructions, then rst during WRITEBACK of a store.
    mem[0] = 16'h0080;
    mem[1] = 16'h2000;
    mem[2] = 16'h2080;
    mem[3] = 16'h2000;
    reset_dut();
    for (int i = 0; i < 3; i++) step(0, 2);
`ifdef CPU_SEQ_PERF_EN
    check("retired_three", 32'(bus.retired), 32'd3);
`endif
    check("pre_abort_pc", 32'(bus.pc), 32'h0003);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    check("abort_in_wb", 32'(bus.state), 32'd3);
    check("mem_we_before_rst", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("mem_we_during_rst", 32'(bus.mem_we), 32'd0);
    tick();
    check_reset_state();
    rst = 1'b0;

    // Randomized program.
    reset_dut();
    for (int i = 0; i < 300 && !m_halted; i++)
      step(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 2);
    if (!m_halted) begin
      mem[m_pc] = HALT_WORD;
      step(0, 2);
    end
    repeat (4) tick();
    check("random_halted", 32'(bus.halted), 32'd1);

    // PC_LIMIT=3 instance: linear code halts at fetch of pc 4.
    reset_dut();
    run_lim = 1'b1;
    repeat (16) tick();
    check("lim_pc_before", 32'(bus_lim.pc), 32'h0004);
    check("lim_halted_before", 32'(bus_lim.halted), 32'd0);
    check("lim_state_before", 32'(bus_lim.state), 32'd0);
    tick();
    check("lim_halted", 32'(bus_lim.halted), 32'd1);
    check("lim_state", 32'(bus_lim.state), 32'd4);
    check("lim_pc", 32'(bus_lim.pc), 32'h0004);
    check("lim_ir", 32'(bus_lim.ir), 32'h0080);
    repeat (3) tick();
    check("lim_hold_pc", 32'(bus_lim.pc), 32'h0004);
    run_lim = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
